key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter NKEYS, default 4, meaning the number of independent push-button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the stable-input cycles required before an output change (10 ms at 50 MHz).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 25000000, meaning the press-hold cycles before the first repeat pulse (used only with the repeat feature).
REQ-004 The block SHALL have parameter REPEAT_CYCLES, default 5000000, meaning the cycles between repeat pulses (used only with the repeat feature).
REQ-005 The block SHALL have port clk, input, 1 bit: the system clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port key_raw, input, NKEYS bits: raw asynchronous button levels, active-low (0 = pressed).
REQ-008 The block SHALL have port key_out, output, NKEYS bits: registered debounced levels, active-low, feeding the key PIO input port.
REQ-009 The block SHALL have port press_pulse, output, NKEYS bits: registered one-cycle strobes marking a debounced press.

Function
REQ-010 Each channel SHALL pass key_raw through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-011 Each channel SHALL hold a counter of width ceil(log2(DEBOUNCE_CYCLES)), minimum 1, that never exceeds DEBOUNCE_CYCLES-1 and never wraps.
REQ-012 Per clock, the channel SHALL clear the counter when sync2 equals key_out.
REQ-013 Per clock, the channel SHALL increment the counter when sync2 differs from key_out and the counter is below DEBOUNCE_CYCLES-1.
REQ-014 Per clock, when sync2 differs from key_out and the counter equals DEBOUNCE_CYCLES-1, the channel SHALL load key_out from sync2 and clear the counter.
REQ-015 A key_raw step held stable SHALL appear on key_out at rising edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new level as edge 1.
REQ-016 Any bounce that returns sync2 to key_out's value before the terminal count SHALL clear the counter and leave key_out unchanged.
REQ-017 press_pulse[i] SHALL assert for exactly one cycle, on the same edge that key_out[i] transitions 1->0.
REQ-018 press_pulse[i] SHALL remain 0 on 0->1 (release) transitions.
REQ-019 Channels SHALL be fully independent; simultaneous events on several keys SHALL produce simultaneous, independent outputs.
REQ-020 Parameter values DEBOUNCE_CYCLES < 1, HOLD_CYCLES < 1 or REPEAT_CYCLES < 1 SHALL be rejected at elaboration.

Reset
REQ-021 While reset_n=0, sync1, sync2 and key_out SHALL be all ones (released).
REQ-022 While reset_n=0, all counters and press_pulse SHALL be 0.
REQ-023 Reset asserted mid-count SHALL abort the debounce immediately, with no pulse generated.
REQ-024 A key held pressed across reset release SHALL be re-debounced from zero and produce one press_pulse.

Configuration
REQ-025 Macro KEY_DEBOUNCE_REPEAT_EN, when defined, SHALL add a per-key hold counter that runs while key_out[i]=0 and clears when key_out[i] returns to 1.
REQ-026 With KEY_DEBOUNCE_REPEAT_EN defined, press_pulse[i] SHALL additionally assert for one cycle at HOLD_CYCLES, HOLD_CYCLES+REPEAT_CYCLES, HOLD_CYCLES+2*REPEAT_CYCLES, and so on, measured in cycles after the initial press pulse, for as long as the key stays pressed.
REQ-027 With KEY_DEBOUNCE_REPEAT_EN undefined, no hold counter SHALL exist and exactly one press_pulse SHALL occur per debounced press.
REQ-028 key_out behaviour SHALL be identical whether or not KEY_DEBOUNCE_REPEAT_EN is defined.

Verification (NKEYS=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3)
REQ-029 Reset: hold reset_n=0 with key_raw=4'h0 -> key_out=4'hF and press_pulse=4'h0 throughout reset.
REQ-030 Press: key_raw[0] goes 1->0 and is held -> key_out[0]=0 from edge 6, press_pulse=4'h1 for the edge-6 cycle only.
REQ-031 Bounce: key_raw[1] is low for 3 cycles, then high -> key_out stays 4'hF and press_pulse stays 0.
REQ-032 Release: after the press, key_raw[0] goes 0->1 -> key_out[0]=1 at edge 6 and no pulse occurs.
REQ-033 Repeat: hold key 2 for 20 cycles after its press pulse -> with the macro, pulses at +8, +11, +14 and +17; without the macro, none.
REQ-034 Simultaneous/reset: keys 0 and 3 pressed in the same cycle -> press_pulse=4'h9 in a single cycle; reset_n pulsed low at count 2 -> key_out=4'hF immediately and the count restarts.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: per-key 2-flop sync, stable-count debounce, press strobe.
// Optional auto-repeat on long hold via KEY_DEBOUNCE_REPEAT_EN.
module key_debounce #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] key_out,
  output logic [NKEYS-1:0] press_pulse
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("key_debounce: DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end
  logic [NKEYS-1:0]         sync1_q, sync2_q, key_q, key_d, pulse_q, pulse_d;
  logic [NKEYS-1:0][CW-1:0] cnt_q, cnt_d;
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RLAST = HW'(REPEAT_CYCLES - 1);
  logic [NKEYS-1:0][HW-1:0] hcnt_q, hcnt_d;
  logic [NKEYS-1:0]         rep_q, rep_d, run, hit;
`endif
  always_comb begin
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i]   = (sync2_q[i] != key_q[i] && cnt_q[i] != LAST) ? cnt_q[i] + CW'(1) : '0;
      key_d[i]   = (sync2_q[i] != key_q[i] && cnt_q[i] == LAST) ? sync2_q[i] : key_q[i];
      pulse_d[i] = key_q[i] && !key_d[i];
`ifdef KEY_DEBOUNCE_REPEAT_EN
      // first repeat after HOLD_CYCLES, then every REPEAT_CYCLES while still held
      run[i]     = !key_q[i] && !key_d[i];
      hit[i]     = run[i] && hcnt_q[i] == (rep_q[i] ? RLAST : HLAST);
      hcnt_d[i]  = (run[i] && !hit[i]) ? hcnt_q[i] + HW'(1) : '0;
      rep_d[i]   = run[i] && (rep_q[i] || hit[i]);
      pulse_d[i] = pulse_d[i] || hit[i];
`endif
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      key_q   <= '1;
      cnt_q   <= '0;
      pulse_q <= '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      hcnt_q  <= '0;
      rep_q   <= '0;
`endif
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      hcnt_q  <= hcnt_d;
      rep_q   <= rep_d;
`endif
    end
  end
  assign key_out     = key_q;
  assign press_pulse = pulse_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: random + directed stimulus against a streak-based reference model.
module tb_key_debounce;
  localparam int N = 4, D = 4, H = 8, R = 3;
  logic clk = 0, reset_n = 0;
  logic [N-1:0] key_raw = '0, key_out, press_pulse;
  int checks = 0, failures = 0;
  key_debounce #(.NKEYS(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .key_out(key_out), .press_pulse(press_pulse)
  );
  always #5 clk = ~clk;
  // model: raw delayed two samples; output follows after D consecutive disagreeing samples
  logic [N-1:0] m_s1, m_s2, m_key, m_pulse;
  int m_run [N];
  int m_t   [N];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '1; m_s2 = '1; m_key = '1; m_pulse = '0;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_t[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_run[i] = (m_s2[i] != m_key[i]) ? m_run[i] + 1 : 0;
        m_pulse[i] = 1'b0;
        if (m_run[i] == D) begin
          m_key[i] = m_s2[i];
          m_run[i] = 0;
          m_t[i] = 0;
          m_pulse[i] = !m_key[i];
        end else if (!m_key[i]) begin
          m_t[i]++;
`ifdef KEY_DEBOUNCE_REPEAT_EN
          if (m_t[i] >= H && (m_t[i] - H) % R == 0) m_pulse[i] = 1'b1;
`endif
        end
      end
      m_s2 = m_s1;
      m_s1 = key_raw;
    end
  end
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("model_key_out", key_out, m_key);
    chk("model_press_pulse", press_pulse, m_pulse);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input logic [N-1:0] v);
    #1 key_raw = v;
  endtask
  initial begin
    int rate;
    logic [N-1:0] exp_p;
    key_raw = '0;
    cyc(1); chk("rst_key", key_out, 4'hF); chk("rst_pulse", press_pulse, 4'h0);
    cyc(3); chk("rst_key_late", key_out, 4'hF); chk("rst_pulse_late", press_pulse, 4'h0);
    drive(4'hF); reset_n = 1; cyc(10);
    drive(4'hE); cyc(5);
    chk("press_e5_key", key_out, 4'hF); chk("press_e5_pulse", press_pulse, 4'h0);
    cyc(1); chk("press_e6_key", key_out, 4'hE); chk("press_e6_pulse", press_pulse, 4'h1);
    cyc(1); chk("press_e7_pulse", press_pulse, 4'h0);
    drive(4'hC); cyc(3); drive(4'hE); cyc(10);
    chk("bounce_key", key_out, 4'hE);
    drive(4'hF); cyc(5); chk("release_e5_key", key_out, 4'hE);
    cyc(1); chk("release_e6_key", key_out, 4'hF); chk("release_e6_pulse", press_pulse, 4'h0);
    cyc(4);
    drive(4'hB); cyc(6); chk("hold_press_pulse", press_pulse, 4'h4);
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
`ifdef KEY_DEBOUNCE_REPEAT_EN
      exp_p = (k == 8 || k == 11 || k == 14 || k == 17) ? 4'h4 : 4'h0;
`else
      exp_p = 4'h0;
`endif
      chk($sformatf("repeat_plus%0d", k), press_pulse, exp_p);
    end
    drive(4'hF); cyc(10);
    drive(4'h6); cyc(6);
    chk("simul_pulse", press_pulse, 4'h9); chk("simul_key", key_out, 4'h6);
    cyc(1); chk("simul_pulse_next", press_pulse, 4'h0);
    drive(4'hF); cyc(10);
    drive(4'hE); cyc(4);
    #1 reset_n = 0; #1 chk("midrst_key", key_out, 4'hF); chk("midrst_pulse", press_pulse, 4'h0);
    cyc(2); #1 reset_n = 1; cyc(5);
    chk("rerun_e5_key", key_out, 4'hF); chk("rerun_e5_pulse", press_pulse, 4'h0);
    cyc(1); chk("rerun_e6_key", key_out, 4'hE); chk("rerun_e6_pulse", press_pulse, 4'h1);
    drive(4'hF); cyc(10);
    for (int c = 0; c < 4000; c++) begin
      cyc(1);
      rate = ((c / 500) % 2) ? 40 : 5;
      #1;
      if ($urandom_range(0, 399) == 0) reset_n = 0;
      else reset_n = 1;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, rate - 1) == 0) key_raw[i] = ~key_raw[i];
    end
    cyc(1); #1 reset_n = 1; cyc(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
